// File: rtl/prescale_timer_multi.sv
// prescale_timer_multi
//
// One shared prescaler produces a tick that advances NUM_CH independent
// channel counters. Each channel runs as a toggle, PWM or one-shot timer
// with its own terminal count (period) and duty threshold (compare).
//
// Ports:
//   clk, rst          system clock (posedge) and asynchronous active-high reset
//   enable            global run; low freezes the prescaler and forces tick=0
//   prescaler_preset  prescaler reload value; tick rate is clk/(preset+1)
//   ch_enable[i]      channel run enable; low clears count, out and busy
//   ch_mode[2i+1:2i]  0 toggle, 1 PWM, 2 one-shot, 3 reserved (held idle)
//   ch_period slice i terminal count; one period spans period+1 ticks
//   ch_compare slice i PWM threshold: out high while next count < compare
//   ch_restart[i]     synchronous restart / one-shot arm, beats a tick
//   tick              enable && prescaler==0 (combinational)
//   ch_out[i]         registered channel waveform
//   ch_wrap[i]        registered one-clk pulse when the count wraps at period
//   ch_busy[i]        one-shot running flag, 0 in all other modes
module prescale_timer_multi #(
    parameter int PRESCALER_BITS = 8,
    parameter int COUNTER_BITS   = 16,
    parameter int NUM_CH         = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [PRESCALER_BITS-1:0]      prescaler_preset,
    input  logic [NUM_CH-1:0]              ch_enable,
    input  logic [2*NUM_CH-1:0]            ch_mode,
    input  logic [COUNTER_BITS*NUM_CH-1:0] ch_period,
    input  logic [COUNTER_BITS*NUM_CH-1:0] ch_compare,
    input  logic [NUM_CH-1:0]              ch_restart,
    output logic                           tick,
    output logic [NUM_CH-1:0]              ch_out,
    output logic [NUM_CH-1:0]              ch_wrap,
    output logic [NUM_CH-1:0]              ch_busy
);

    localparam logic [1:0] MODE_TOGGLE  = 2'd0;
    localparam logic [1:0] MODE_PWM     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    localparam logic [PRESCALER_BITS-1:0] P_ONE = {{(PRESCALER_BITS-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_BITS-1:0]   C_ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

    logic [PRESCALER_BITS-1:0] presc_q, presc_d;
    logic [COUNTER_BITS-1:0]   count_q [NUM_CH];
    logic [COUNTER_BITS-1:0]   count_d [NUM_CH];
    logic [NUM_CH-1:0]         out_q, out_d;
    logic [NUM_CH-1:0]         wrap_q, wrap_d;
    logic [NUM_CH-1:0]         busy_q, busy_d;

    // Per-channel views of the packed configuration buses.
    logic [1:0]              mode_a    [NUM_CH];
    logic [COUNTER_BITS-1:0] period_a  [NUM_CH];
    logic [COUNTER_BITS-1:0] compare_a [NUM_CH];
    logic [COUNTER_BITS-1:0] next_a    [NUM_CH];
    logic [COUNTER_BITS-1:0] inc_a     [NUM_CH];
    logic [NUM_CH-1:0]       at_end;

    assign tick = enable && (presc_q == '0);

    // Prescaler counts down and reloads on zero, so a new preset is only
    // picked up at the next reload.
    always_comb begin
        presc_d = presc_q;
        if (enable) begin
            presc_d = (presc_q == '0) ? prescaler_preset : (presc_q - P_ONE);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_view
        assign mode_a[g]    = ch_mode[2*g +: 2];
        assign period_a[g]  = ch_period[COUNTER_BITS*g +: COUNTER_BITS];
        assign compare_a[g] = ch_compare[COUNTER_BITS*g +: COUNTER_BITS];
        assign at_end[g]    = (count_q[g] == period_a[g]);
        // Plain increment rolls through 2^COUNTER_BITS when the period was
        // lowered below the current count; that rollover is not a wrap.
        assign inc_a[g]     = count_q[g] + C_ONE;
        assign next_a[g]    = at_end[g] ? '0 : inc_a[g];
    end

    always_comb begin
        out_d  = out_q;
        busy_d = busy_q;
        wrap_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            if (!ch_enable[i]) begin
                count_d[i] = '0;
                out_d[i]   = 1'b0;
                busy_d[i]  = 1'b0;
            end else if (ch_restart[i]) begin
                count_d[i] = '0;
                case (mode_a[i])
                    MODE_TOGGLE: out_d[i] = 1'b0;
                    MODE_PWM:    out_d[i] = (compare_a[i] != '0);
                    MODE_ONESHOT: begin
                        // Re-arming while busy keeps out high: no glitch.
                        out_d[i]  = 1'b1;
                        busy_d[i] = 1'b1;
                    end
                    default: begin
                        out_d[i]  = 1'b0;
                        busy_d[i] = 1'b0;
                    end
                endcase
            end else if (tick) begin
                case (mode_a[i])
                    MODE_TOGGLE: begin
                        count_d[i] = next_a[i];
                        wrap_d[i]  = at_end[i];
                        if (at_end[i]) out_d[i] = ~out_q[i];
                    end
                    MODE_PWM: begin
                        count_d[i] = next_a[i];
                        wrap_d[i]  = at_end[i];
                        out_d[i]   = (next_a[i] < compare_a[i]);
                    end
                    MODE_ONESHOT: begin
                        if (busy_q[i]) begin
                            count_d[i] = next_a[i];
                            wrap_d[i]  = at_end[i];
                            if (at_end[i]) begin
                                out_d[i]  = 1'b0;
                                busy_d[i] = 1'b0;
                            end
                        end
                    end
                    default: begin
                        count_d[i] = '0;
                        out_d[i]   = 1'b0;
                        busy_d[i]  = 1'b0;
                    end
                endcase
            end
            // busy only has meaning in one-shot mode.
            if (mode_a[i] != MODE_ONESHOT) busy_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            out_q   <= '0;
            wrap_q  <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) count_q[i] <= '0;
        end else begin
            presc_q <= presc_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NUM_CH; i++) count_q[i] <= count_d[i];
        end
    end

    assign ch_out  = out_q;
    assign ch_wrap = wrap_q;
    assign ch_busy = busy_q;

endmodule

// File: tb/tb_prescale_timer_multi.sv
module tb_prescale_timer_multi;

    localparam int P   = 8;
    localparam int C   = 16;
    localparam int N   = 4;
    localparam int MOD = 1 << C;
    localparam int EW  = 3*N + 1;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [P-1:0]   prescaler_preset;
    logic [N-1:0]   ch_enable;
    logic [2*N-1:0] ch_mode;
    logic [C*N-1:0] ch_period;
    logic [C*N-1:0] ch_compare;
    logic [N-1:0]   ch_restart;
    logic           tick;
    logic [N-1:0]   ch_out;
    logic [N-1:0]   ch_wrap;
    logic [N-1:0]   ch_busy;

    prescale_timer_multi #(.PRESCALER_BITS(P), .COUNTER_BITS(C), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .prescaler_preset(prescaler_preset),
        .ch_enable(ch_enable), .ch_mode(ch_mode), .ch_period(ch_period),
        .ch_compare(ch_compare), .ch_restart(ch_restart), .tick(tick),
        .ch_out(ch_out), .ch_wrap(ch_wrap), .ch_busy(ch_busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_presc;
    int m_cnt [N];
    bit m_out [N];
    bit m_busy[N];
    bit m_wrap[N];

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic void model_reset();
        m_presc = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_out[i] = 0; m_busy[i] = 0; m_wrap[i] = 0;
        end
    endfunction

    function automatic logic [EW-1:0] model_pack();
        logic [EW-1:0] e;
        e[3*N] = enable && (m_presc == 0);
        for (int i = 0; i < N; i++) begin
            e[2*N + i] = m_out[i];
            e[N + i]   = m_wrap[i];
            e[i]       = m_busy[i];
        end
        return e;
    endfunction

    // Effect of one rising clock edge with the currently applied inputs.
    function automatic void model_edge();
        bit tk;
        int mode, per, cmp;
        if (rst) begin
            model_reset();
            return;
        end
        tk = enable && (m_presc == 0);
        if (enable) m_presc = (m_presc == 0) ? int'(prescaler_preset) : m_presc - 1;
        for (int i = 0; i < N; i++) begin
            mode = int'(ch_mode[2*i +: 2]);
            per  = int'(ch_period[C*i +: C]);
            cmp  = int'(ch_compare[C*i +: C]);
            m_wrap[i] = 0;
            if (!ch_enable[i]) begin
                m_cnt[i] = 0; m_out[i] = 0; m_busy[i] = 0;
            end else if (ch_restart[i]) begin
                m_cnt[i] = 0;
                if (mode == 2) begin
                    m_out[i] = 1; m_busy[i] = 1;
                end else begin
                    m_out[i] = (mode == 1) ? (cmp > 0) : 1'b0;
                    m_busy[i] = 0;
                end
            end else if (tk) begin
                if (mode == 3) begin
                    m_cnt[i] = 0; m_out[i] = 0; m_busy[i] = 0;
                end else if (mode != 2 || m_busy[i]) begin
                    if (m_cnt[i] == per) begin
                        m_cnt[i] = 0;
                        m_wrap[i] = 1;
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1) % MOD;
                    end
                    if (mode == 0 && m_wrap[i]) m_out[i] = !m_out[i];
                    if (mode == 1) m_out[i] = (m_cnt[i] < cmp);
                    if (mode == 2 && m_wrap[i]) begin
                        m_out[i] = 0; m_busy[i] = 0;
                    end
                end
            end
            if (mode != 2) m_busy[i] = 0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; advances one clock.
    task automatic step();
        model_edge();
        exp_q.push_back(model_pack());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_ch(input int i, input int mode, input int per, input int cmp);
        ch_mode[2*i +: 2]   = mode[1:0];
        ch_period[C*i +: C] = per[C-1:0];
        ch_compare[C*i +: C] = cmp[C-1:0];
    endtask

    task automatic pulse_restart(input int i);
        ch_restart[i] = 1'b1;
        step();
        ch_restart[i] = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {tick, ch_out, ch_wrap, ch_busy};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL cycle_outputs t=%0t {tick,out,wrap,busy} got=%b expected=%b",
                             $time, got, e);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1; enable = 1'b0; prescaler_preset = '0; ch_enable = '0;
        ch_mode = '0; ch_period = '0; ch_compare = '0; ch_restart = '0;
        model_reset();
        @(negedge clk);
        run(3);

        // Toggle channel 0, tick every cycle.
        rst = 1'b0; enable = 1'b1;
        ch_enable[0] = 1'b1; set_ch(0, 0, 3, 0);
        run(40);

        // PWM channel 1 at clk/5 with several duty settings.
        prescaler_preset = 8'd4;
        ch_enable[1] = 1'b1; set_ch(1, 1, 9, 3);
        run(120);
        set_ch(1, 1, 9, 0);
        run(60);
        set_ch(1, 1, 9, 12);
        run(60);

        // One-shot channel 2: single shot, then re-arm mid-shot.
        prescaler_preset = 8'd0;
        run(6);
        ch_enable[2] = 1'b1; set_ch(2, 2, 5, 0);
        run(2);
        pulse_restart(2);
        run(12);
        pulse_restart(2);
        run(3);
        pulse_restart(2);
        run(15);

        // Freeze, then disable channel 0 mid-count.
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(3);
        ch_enable[0] = 1'b0;
        run(2);
        ch_enable[0] = 1'b1;
        run(5);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({ch_out, ch_wrap, ch_busy} !== '0 || tick !== enable) begin
            bad++;
            $display("FAIL async_reset {out,wrap,busy} got=%b expected=0 tick got=%b expected=%b",
                     {ch_out, ch_wrap, ch_busy}, tick, enable);
        end
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(20);

        // Restart colliding with a tick, then period lowered below count.
        pulse_restart(0);
        run(5);
        set_ch(0, 0, 9, 0);
        guard = 0;
        while (m_cnt[0] != 7 && guard < 40) begin
            step();
            guard++;
        end
        total++;
        if (m_cnt[0] != 7) begin
            bad++;
            $display("FAIL reach_count7 model count got=%0d expected=7", m_cnt[0]);
        end
        set_ch(0, 0, 2, 0);
        run(MOD + 20);

        // Randomized traffic on all channels.
        for (int k = 0; k < 4000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) prescaler_preset = P'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                ch_restart[i] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 99) == 0) ch_enable[i] = ~ch_enable[i];
                if ($urandom_range(0, 59) == 0)
                    set_ch(i, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14));
            end
            step();
        end
        ch_restart = '0;
        run(4);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prescale_timer_multi.md
Name: prescale_timer_multi

Overview:
Multi-channel timer. One shared prescaler generates a tick that drives NUM_CH independent channel counters. Each channel runs in toggle, PWM or one-shot mode and has its own period and compare value. The block sits between the system clock and the LED/PWM/event outputs, and provides periodic strobes to downstream logic.

Parameters:
PRESCALER_BITS, 8, width of the shared prescaler; tick divides clk by prescaler_preset+1
COUNTER_BITS, 16, width of each channel counter, period and compare value
NUM_CH, 4, number of independent channels (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
enable  input  1  global run; low freezes the prescaler and suppresses ticks
prescaler_preset  input  PRESCALER_BITS  prescaler reload value
ch_enable  input  NUM_CH  per-channel run enable
ch_mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 0 toggle, 1 PWM, 2 one-shot, 3 reserved
ch_period  input  COUNTER_BITS*NUM_CH  per-channel terminal count, slice i = [C*i+C-1:C*i]
ch_compare  input  COUNTER_BITS*NUM_CH  per-channel PWM duty threshold
ch_restart  input  NUM_CH  per-channel synchronous restart/arm pulse
tick  output  1  prescaler tick = enable && (prescaler==0); combinational from register state and input
ch_out  output  NUM_CH  registered channel waveform
ch_wrap  output  NUM_CH  registered one-cycle pulse when a channel count wraps
ch_busy  output  NUM_CH  one-shot running flag; 0 in other modes

Behaviour:
- Reset (async, rst=1): prescaler=0, all counts=0, ch_out=0, ch_wrap=0, ch_busy=0. Takes effect immediately, including mid-operation. No port values are loaded during reset.
- Prescaler:
  - On each posedge with enable=1: if prescaler==0, reload prescaler_preset; else decrement.
  - enable=0: prescaler holds and tick=0.
  - preset=0: tick every cycle.
  - A preset change takes effect at the next reload only.
- Channel i steps only on edges where tick=1 and ch_enable[i]=1.
  - Step: if count==period, count<=0 and ch_wrap[i]<=1; else count<=count+1.
  - One period spans period+1 ticks. period=0 wraps on every tick.
  - ch_wrap[i] is cleared on every edge where it is not set, so it is high for exactly one clk.
- ch_enable[i]=0: synchronously clears count, ch_out[i] and ch_busy[i] to 0.
- ch_restart[i]=1: synchronously sets count=0 and ch_wrap[i]=0.
  - Restart has priority over a tick in the same cycle.
  - Honoured only when ch_enable[i]=1.
- Toggle mode (0): ch_out[i] inverts on each wrap. Restart clears ch_out[i].
- PWM mode (1):
  - On each step, ch_out[i] <= (next_count < compare), unsigned.
  - compare=0: constant low. compare>period: constant high.
  - On restart, ch_out[i] <= (0 < compare).
- One-shot mode (2):
  - Restart sets ch_busy=1 and ch_out=1.
  - Steps occur only while busy.
  - On wrap: ch_out=0, ch_busy=0, count=0. No further steps until the next restart.
  - A restart while busy re-arms from 0 with no glitch low on ch_out.
- Reserved mode (3): count, ch_out and ch_busy held at 0. No wraps.
- Mode, period and compare changes take effect on the next step; no forced output update.
- Period lowered below the current count: the counter counts up through the 2^COUNTER_BITS wrap to 0, then resumes normally. No wrap pulse at the overflow.
- Channels are fully independent. Simultaneous wraps on several channels all pulse in the same cycle.

Test Plan:
- Reset, enable=1, preset=0, ch0 toggle, period=3 -> tick every cycle; ch_wrap[0] pulses every 4 clk; ch_out[0] has a period of 8 clk, first rise 4 clk after the first tick.
- preset=4, ch1 PWM, period=9, compare=3 -> tick every 5 clk; ch_out[1] high 3 ticks and low 7 ticks per 10-tick cycle. compare=0 -> constant low; compare=12 -> constant high.
- ch2 one-shot, period=5, preset=0, restart pulse -> ch_busy/ch_out high for exactly 6 ticks, one wrap pulse, then idle. Restart at tick 3 extends high to 9 ticks total.
- Mid-count: enable=0 for 10 cycles -> prescaler, counts and outputs frozen. Then ch_enable[0]=0 -> count and out cleared next edge.
- Assert rst asynchronously between clk edges mid-period -> all outputs 0 before the next edge. Release -> toggle channel restarts from count 0.
- Restart and tick in the same cycle on ch0 -> count=0, no wrap pulse. Lower period from 9 to 2 while count=7 -> counter wraps through 2^16 to 0 with no wrap pulse, then wraps every 3 ticks.
